// File: rtl/maze_pkg.sv
// Shared maze definitions: direction and FSM encodings plus flat cell/wall bit indexing.
package maze_pkg;

    typedef enum logic [1:0] {
        DIR_RIGHT = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_UP    = 2'd3
    } dir_t;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DECIDE   = 3'd1,
        ST_MOVE     = 3'd2,
        ST_WAIT_ACK = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

    function automatic int cell_index(input int col, input int row, input int grid_w);
        return row * grid_w + col;
    endfunction

    // Wall above cell (col,row); row == GRID_H addresses the bottom edge.
    function automatic int h_wall_index(input int col, input int row, input int grid_w);
        return row * grid_w + col;
    endfunction

    // Wall left of cell (col,row); col == GRID_W addresses the right edge.
    function automatic int v_wall_index(input int col, input int row, input int grid_w);
        return row * (grid_w + 1) + col;
    endfunction

    // Right<->left and down<->up differ only in bit 1.
    function automatic dir_t opposite(input dir_t d);
        return dir_t'(d ^ 2'd2);
    endfunction

endpackage

// File: rtl/maze_wall_lookup.sv
// Combinational free-direction lookup for one cell: a direction is free when no wall
// bit blocks it and the neighbouring cell lies inside the grid.
module maze_wall_lookup
    import maze_pkg::*;
#(
    parameter int GRID_W = 10,
    parameter int GRID_H = 15,
    parameter int COL_W  = 4,
    parameter int ROW_W  = 4,
    localparam int HW_N  = (GRID_H + 1) * GRID_W,
    localparam int VW_N  = GRID_H * (GRID_W + 1)
) (
    input  logic [COL_W-1:0] col_i,
    input  logic [ROW_W-1:0] row_i,
    input  logic [HW_N-1:0]  h_walls_i,
    input  logic [VW_N-1:0]  v_walls_i,
    output logic [3:0]       free_o
);

    int   c;
    int   r;
    logic wall_left;
    logic wall_right;
    logic wall_up;
    logic wall_down;

    always_comb begin
        c = int'(col_i);
        r = int'(row_i);
        wall_left  = |(v_walls_i & (VW_N'(1) << v_wall_index(c,     r,     GRID_W)));
        wall_right = |(v_walls_i & (VW_N'(1) << v_wall_index(c + 1, r,     GRID_W)));
        wall_up    = |(h_walls_i & (HW_N'(1) << h_wall_index(c,     r,     GRID_W)));
        wall_down  = |(h_walls_i & (HW_N'(1) << h_wall_index(c,     r + 1, GRID_W)));
        free_o            = '0;
        free_o[DIR_RIGHT] = (c < GRID_W - 1) && !wall_right;
        free_o[DIR_DOWN]  = (r < GRID_H - 1) && !wall_down;
        free_o[DIR_LEFT]  = (c > 0) && !wall_left;
        free_o[DIR_UP]    = (r > 0) && !wall_up;
    end

endmodule

// File: rtl/player_motion.sv
// Grid-walking player: direction decisions at cell corners, speed-divided pixel steps,
// visited-cell bookkeeping and a position update handshake toward the renderer.
module player_motion
    import maze_pkg::*;
#(
    parameter int GRID_W       = 10,
    parameter int GRID_H       = 15,
    parameter int CELL_BITS    = 5,
    parameter int SPEED_FACTOR = 8,
    localparam int PX_W    = $clog2(GRID_W) + CELL_BITS,
    localparam int PY_W    = $clog2(GRID_H) + CELL_BITS,
    localparam int N_CELLS = GRID_W * GRID_H,
    localparam int VC_W    = $clog2(N_CELLS + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic                          restart,
    input  logic [3:0]                    btn,
    input  logic [(GRID_H+1)*GRID_W-1:0]  h_walls,
    input  logic [GRID_H*(GRID_W+1)-1:0]  v_walls,
    input  logic                          upd_ready,
    output logic                          upd_valid,
    output logic [PX_W-1:0]               pos_x,
    output logic [PY_W-1:0]               pos_y,
    output logic [1:0]                    direction,
    output logic [N_CELLS-1:0]            visited,
    output logic [VC_W-1:0]               visited_count,
    output logic                          done,
    output logic [2:0]                    state_dbg
);

    localparam int COL_W = (GRID_W > 1) ? $clog2(GRID_W) : 1;
    localparam int ROW_W = (GRID_H > 1) ? $clog2(GRID_H) : 1;
    localparam int CNT_W = $clog2(SPEED_FACTOR);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SPEED_FACTOR - 1);

    // Handshake: upd_valid rises with a freshly stepped position and stays high, with the
    // position frozen, until upd_ready is high at a rising edge; that edge consumes it.

    state_t               state_q, state_d;
    logic [PX_W-1:0]      pos_x_q, pos_x_d;
    logic [PY_W-1:0]      pos_y_q, pos_y_d;
    dir_t                 dir_q, dir_d;
    logic                 path_free_q, path_free_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [N_CELLS-1:0]   visited_q, visited_d;
    logic [VC_W-1:0]      vcount_q, vcount_d;

    logic                 aligned;
    logic [COL_W-1:0]     cell_col;
    logic [ROW_W-1:0]     cell_row;
    logic [N_CELLS-1:0]   cell_mask;
    logic [VC_W-1:0]      vcount_bump;
    logic [3:0]           free;
    logic [3:0]           pick;
    dir_t                 dir_pick;
    logic                 reverse_req;
    logic                 tick;

    always_comb begin
        aligned     = (pos_x_q[CELL_BITS-1:0] == '0) && (pos_y_q[CELL_BITS-1:0] == '0);
        cell_col    = COL_W'(pos_x_q >> CELL_BITS);
        cell_row    = ROW_W'(pos_y_q >> CELL_BITS);
        cell_mask   = N_CELLS'(1) << cell_index(int'(cell_col), int'(cell_row), GRID_W);
        vcount_bump = ((visited_q & cell_mask) == '0) ? vcount_q + VC_W'(1) : vcount_q;
        reverse_req = (state_q == ST_MOVE) && !aligned && btn[opposite(dir_q)];
        tick        = (state_q == ST_MOVE) && enable && !reverse_req && (cnt_q == '0);
    end

    maze_wall_lookup #(
        .GRID_W (GRID_W),
        .GRID_H (GRID_H),
        .COL_W  (COL_W),
        .ROW_W  (ROW_W)
    ) u_walls (
        .col_i     (cell_col),
        .row_i     (cell_row),
        .h_walls_i (h_walls),
        .v_walls_i (v_walls),
        .free_o    (free)
    );

    // Lowest-index requested direction that is open wins; otherwise keep heading.
    always_comb begin
        pick = btn & free;
        if (pick[0])      dir_pick = DIR_RIGHT;
        else if (pick[1]) dir_pick = DIR_DOWN;
        else if (pick[2]) dir_pick = DIR_LEFT;
        else if (pick[3]) dir_pick = DIR_UP;
        else              dir_pick = dir_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (restart) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:     if (enable) state_d = ST_DECIDE;
                ST_DECIDE:   state_d = (vcount_bump == VC_W'(N_CELLS)) ? ST_DONE : ST_MOVE;
                ST_MOVE:     if (tick) state_d = path_free_q ? ST_WAIT_ACK : ST_DECIDE;
                ST_WAIT_ACK: if (upd_ready) state_d = aligned ? ST_DECIDE : ST_MOVE;
                ST_DONE:     state_d = ST_DONE;
                default:     state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        upd_valid     = (state_q == ST_WAIT_ACK);
        done          = (state_q == ST_DONE);
        state_dbg     = state_q;
        pos_x         = pos_x_q;
        pos_y         = pos_y_q;
        direction     = dir_q;
        visited       = visited_q;
        visited_count = vcount_q;
    end

    always_comb begin
        pos_x_d     = pos_x_q;
        pos_y_d     = pos_y_q;
        dir_d       = dir_q;
        path_free_d = path_free_q;
        cnt_d       = cnt_q;
        visited_d   = visited_q;
        vcount_d    = vcount_q;
        if (restart) begin
            pos_x_d     = '0;
            pos_y_d     = '0;
            dir_d       = DIR_LEFT;
            path_free_d = 1'b0;
            cnt_d       = '0;
            visited_d   = '0;
            vcount_d    = '0;
        end else begin
            case (state_q)
                ST_DECIDE: begin
                    visited_d   = visited_q | cell_mask;
                    vcount_d    = vcount_bump;
                    dir_d       = dir_pick;
                    path_free_d = free[dir_pick];
                    cnt_d       = CNT_LOAD;
                end
                ST_MOVE: begin
                    // Reversal keeps the countdown running but never lets it wrap below 0.
                    if (reverse_req) begin
                        dir_d       = opposite(dir_q);
                        path_free_d = 1'b1;
                        if (enable && cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
                    end else if (enable) begin
                        if (cnt_q != '0) begin
                            cnt_d = cnt_q - CNT_W'(1);
                        end else if (path_free_q) begin
                            case (dir_q)
                                DIR_RIGHT: pos_x_d = pos_x_q + PX_W'(1);
                                DIR_DOWN:  pos_y_d = pos_y_q + PY_W'(1);
                                DIR_LEFT:  pos_x_d = pos_x_q - PX_W'(1);
                                DIR_UP:    pos_y_d = pos_y_q - PY_W'(1);
                                default:   pos_x_d = pos_x_q;
                            endcase
                        end
                    end
                end
                ST_WAIT_ACK: if (upd_ready && !aligned) cnt_d = CNT_LOAD;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pos_x_q     <= '0;
            pos_y_q     <= '0;
            dir_q       <= DIR_LEFT;
            path_free_q <= 1'b0;
            cnt_q       <= '0;
            visited_q   <= '0;
            vcount_q    <= '0;
        end else begin
            pos_x_q     <= pos_x_d;
            pos_y_q     <= pos_y_d;
            dir_q       <= dir_d;
            path_free_q <= path_free_d;
            cnt_q       <= cnt_d;
            visited_q   <= visited_d;
            vcount_q    <= vcount_d;
        end
    end

endmodule

// File: tb/tb_player_motion.sv
// Bench for player_motion: a 10x15 instance for motion/handshake behaviour and a 2x1
// instance for grid completion; position updates are checked against an expected queue.
module tb_player_motion;
    import maze_pkg::*;

    localparam int W = 10, H = 15, CB = 5, SF = 8;
    localparam int PXW = $clog2(W) + CB;
    localparam int PYW = $clog2(H) + CB;
    localparam int NC  = W * H;
    localparam int VCW = $clog2(NC + 1);
    localparam int EW  = PXW + PYW + 2;
    localparam int SW = 2, SH = 1;
    localparam int SPXW = $clog2(SW) + CB;
    localparam int SPYW = $clog2(SH) + CB;
    localparam int SNC  = SW * SH;
    localparam int SVCW = $clog2(SNC + 1);
    localparam int SEW  = SPXW + SPYW + 2;

    // ---------------- clock / reset / signals ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, enable, restart, upd_ready, upd_valid, done;
    logic [3:0] btn;
    logic [(H+1)*W-1:0] h_walls;
    logic [H*(W+1)-1:0] v_walls;
    logic [PXW-1:0] pos_x;
    logic [PYW-1:0] pos_y;
    logic [1:0] direction;
    logic [NC-1:0] visited;
    logic [VCW-1:0] visited_count;
    logic [2:0] state_dbg;

    logic rst_s, enable_s, restart_s, upd_ready_s, upd_valid_s, done_s;
    logic [3:0] btn_s;
    logic [(SH+1)*SW-1:0] h_walls_s;
    logic [SH*(SW+1)-1:0] v_walls_s;
    logic [SPXW-1:0] pos_x_s;
    logic [SPYW-1:0] pos_y_s;
    logic [1:0] direction_s;
    logic [SNC-1:0] visited_s;
    logic [SVCW-1:0] visited_count_s;
    logic [2:0] state_dbg_s;

    player_motion #(.GRID_W(W), .GRID_H(H), .CELL_BITS(CB), .SPEED_FACTOR(SF)) dut (
        .clk(clk), .rst(rst), .enable(enable), .restart(restart), .btn(btn),
        .h_walls(h_walls), .v_walls(v_walls), .upd_ready(upd_ready), .upd_valid(upd_valid),
        .pos_x(pos_x), .pos_y(pos_y), .direction(direction), .visited(visited),
        .visited_count(visited_count), .done(done), .state_dbg(state_dbg)
    );

    player_motion #(.GRID_W(SW), .GRID_H(SH), .CELL_BITS(CB), .SPEED_FACTOR(SF)) dut_s (
        .clk(clk), .rst(rst_s), .enable(enable_s), .restart(restart_s), .btn(btn_s),
        .h_walls(h_walls_s), .v_walls(v_walls_s), .upd_ready(upd_ready_s), .upd_valid(upd_valid_s),
        .pos_x(pos_x_s), .pos_y(pos_y_s), .direction(direction_s), .visited(visited_s),
        .visited_count(visited_count_s), .done(done_s), .state_dbg(state_dbg_s)
    );

    // ---------------- scoreboard ----------------
    logic [EW-1:0]  exp_q[$];
    logic [SEW-1:0] exp_s_q[$];
    int tests = 0;
    int fails = 0;
    int handshakes = 0;
    int handshakes_s = 0;

    function automatic logic [EW-1:0] pk(input int x, input int y, input int d);
        return {PXW'(x), PYW'(y), 2'(d)};
    endfunction

    function automatic logic [SEW-1:0] spk(input int x, input int y, input int d);
        return {SPXW'(x), SPYW'(y), 2'(d)};
    endfunction

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (rst && upd_valid && upd_ready) begin
            handshakes++;
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL upd_unexpected: got x=%0d y=%0d dir=%0d, expected no update", pos_x, pos_y, direction);
            end else begin
                e = exp_q.pop_front();
                if ({pos_x, pos_y, direction} !== e) begin
                    fails++;
                    $display("FAIL upd_pos: got x=%0d y=%0d dir=%0d, expected x=%0d y=%0d dir=%0d",
                             pos_x, pos_y, direction, e[EW-1:PYW+2], e[PYW+1:2], e[1:0]);
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [SEW-1:0] e;
        if (rst_s && upd_valid_s && upd_ready_s) begin
            handshakes_s++;
            tests++;
            if (exp_s_q.size() == 0) begin
                fails++;
                $display("FAIL small_upd_unexpected: got x=%0d y=%0d, expected no update", pos_x_s, pos_y_s);
            end else begin
                e = exp_s_q.pop_front();
                if ({pos_x_s, pos_y_s, direction_s} !== e) begin
                    fails++;
                    $display("FAIL small_upd_pos: got x=%0d y=%0d dir=%0d, expected x=%0d y=%0d dir=%0d",
                             pos_x_s, pos_y_s, direction_s, e[SEW-1:SPYW+2], e[SPYW+1:2], e[1:0]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b0; enable = 1'b0; restart = 1'b0; btn = 4'b0; upd_ready = 1'b1;
        h_walls = '0; v_walls = '0;
        cyc(2);
        exp_q.delete();
        handshakes = 0;
        rst = 1'b1;
    endtask

    task automatic wait_empty(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        check(name, 32'(exp_q.size()), 0);
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!upd_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check(name, upd_valid, 1);
    endtask

    // Cycles from MOVE entry (heading d) until upd_valid is seen.
    task automatic measure_step(input string name, input logic [1:0] d);
        int n = 0;
        int lat = 0;
        while (!(state_dbg == ST_MOVE && direction == d) && n < 40) begin
            @(negedge clk);
            n++;
        end
        while (!upd_valid && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        check(name, 32'(lat), 8);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        rst_s = 1'b0; enable_s = 1'b0; restart_s = 1'b0; btn_s = 4'b0; upd_ready_s = 1'b1;
        h_walls_s = '0; v_walls_s = '0;

        // Reset values while rst is held low.
        reset_dut();
        rst = 1'b0;
        cyc(1);
        @(negedge clk);
        check("rst_pos_x", pos_x, 0);
        check("rst_pos_y", pos_y, 0);
        check("rst_direction", direction, 2);
        check("rst_upd_valid", upd_valid, 0);
        check("rst_visited", visited, 0);
        check("rst_count", visited_count, 0);
        check("rst_done", done, 0);

        // No buttons: heading left at (0,0) is blocked by the grid edge.
        reset_dut();
        enable = 1'b1;
        cyc(40);
        @(negedge clk);
        check("idle_no_updates", 32'(handshakes), 0);
        check("idle_direction", direction, 2);
        check("idle_pos", {pos_x, pos_y}, 0);
        check("idle_visited", visited, 1);
        check("idle_count", visited_count, 1);

        // Hold right: first step 8 cycles after MOVE entry, 32 steps to the next cell.
        reset_dut();
        btn = 4'b0001;
        enable = 1'b1;
        for (int i = 1; i <= 32; i++) exp_q.push_back(pk(i, 0, 0));
        measure_step("right_first_latency", 2'd0);
        wait_empty("right_32_steps", 400);
        enable = 1'b0;
        cyc(3);
        @(negedge clk);
        check("right_pos_x", pos_x, 32);
        check("right_visited", visited, 3);
        check("right_count", visited_count, 2);

        // Wall right of (0,0) blocks; adding down turns the player down.
        reset_dut();
        v_walls[1] = 1'b1;
        btn = 4'b0001;
        enable = 1'b1;
        cyc(30);
        @(negedge clk);
        check("wall_no_updates", 32'(handshakes), 0);
        check("wall_direction", direction, 2);
        cyc(1);
        btn = 4'b0011;
        exp_q.push_back(pk(0, 1, 1));
        measure_step("down_first_latency", 2'd1);
        wait_empty("down_step", 40);
        enable = 1'b0;
        @(negedge clk);
        check("down_direction", direction, 1);
        check("down_pos_y", pos_y, 1);

        // Mid-cell reversal at x=10.
        reset_dut();
        btn = 4'b0001;
        enable = 1'b1;
        for (int i = 1; i <= 10; i++) exp_q.push_back(pk(i, 0, 0));
        wait_empty("rev_reach_10", 200);
        btn = 4'b0100;
        exp_q.push_back(pk(9, 0, 2));
        cyc(1);
        btn = 4'b0000;
        @(negedge clk);
        check("rev_direction", direction, 2);
        wait_empty("rev_step_back", 40);
        enable = 1'b0;
        @(negedge clk);
        check("rev_pos_x", pos_x, 9);

        // Stalled renderer, then asynchronous reset in WAIT_ACK.
        reset_dut();
        btn = 4'b0001;
        upd_ready = 1'b0;
        enable = 1'b1;
        exp_q.push_back(pk(1, 0, 0));
        wait_valid("stall_valid_seen");
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("stall_hold", {upd_valid, pos_x, pos_y}, {1'b1, PXW'(1), PYW'(0)});
        end
        #2;
        rst = 1'b0;
        #1;
        check("async_upd_valid", upd_valid, 0);
        check("async_pos", {pos_x, pos_y}, 0);
        check("async_direction", direction, 2);
        check("async_visited", visited, 0);
        check("async_count", visited_count, 0);
        check("async_done", done, 0);
        exp_q.delete();

        // restart beats a simultaneous upd_ready.
        reset_dut();
        btn = 4'b0001;
        upd_ready = 1'b0;
        enable = 1'b1;
        exp_q.push_back(pk(1, 0, 0));
        wait_valid("restart_valid_seen");
        cyc(1);
        restart = 1'b1;
        upd_ready = 1'b1;
        enable = 1'b0;
        btn = 4'b0000;
        cyc(1);
        restart = 1'b0;
        @(negedge clk);
        check("restart_state", state_dbg, ST_IDLE);
        check("restart_upd_valid", upd_valid, 0);
        check("restart_pos_x", pos_x, 0);
        check("restart_count", visited_count, 0);

        // 2x1 grid: walking right fills the grid.
        rst_s = 1'b1;
        enable_s = 1'b1;
        btn_s = 4'b0001;
        for (int i = 1; i <= 32; i++) exp_s_q.push_back(spk(i, 0, 0));
        begin
            int n = 0;
            while ((exp_s_q.size() != 0 || !done_s) && n < 500) begin
                @(negedge clk);
                n++;
            end
        end
        check("small_queue_drained", 32'(exp_s_q.size()), 0);
        check("small_done", done_s, 1);
        check("small_pos_x", pos_x_s, 32);
        check("small_count", visited_count_s, 2);
        check("small_visited", visited_s, 3);
        cyc(20);
        @(negedge clk);
        check("small_done_sticky", done_s, 1);
        check("small_no_extra_updates", 32'(handshakes_s), 32);
        cyc(1);
        restart_s = 1'b1;
        enable_s = 1'b0;
        btn_s = 4'b0000;
        cyc(1);
        restart_s = 1'b0;
        @(negedge clk);
        check("small_restart_done", done_s, 0);
        check("small_restart_pos_x", pos_x_s, 0);
        check("small_restart_count", visited_count_s, 0);

        // ---------------- report ----------------
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/player_motion.md
PLAYER_MOTION -- requirements
Module: player_motion

Interface
REQ-001 SHALL have parameter GRID_W, default 10, maze width in cells.
REQ-002 SHALL have parameter GRID_H, default 15, maze height in cells.
REQ-003 SHALL have parameter CELL_BITS, default 5, cell size 2^CELL_BITS pixels.
REQ-004 SHALL have parameter SPEED_FACTOR, default 8, clocks per one-pixel step, >=2.
REQ-005 SHALL have one clock and reset: clk  in  1  sole clock, rising edge; rst  in  1  asynchronous active-low reset.
REQ-006 SHALL have these ports:
- enable  in  1  motion allowed; low freezes the speed counter.
- restart  in  1  synchronous soft restart, one-cycle pulse.
- btn  in  4  active-high direction requests; bit 0 right, 1 down, 2 left, 3 up.
- h_walls  in  (GRID_H+1)*GRID_W  bit row*GRID_W+col is the wall above cell (col,row).
- v_walls  in  GRID_H*(GRID_W+1)  bit row*(GRID_W+1)+col is the wall left of cell (col,row).
- upd_ready  in  1  renderer accepts an update.
- upd_valid  out  1  new position/direction pending.
- pos_x  out  clog2(GRID_W)+CELL_BITS  pixel x.
- pos_y  out  clog2(GRID_H)+CELL_BITS  pixel y.
- direction  out  2  0 right, 1 down, 2 left, 3 up.
- visited  out  GRID_W*GRID_H  bit row*GRID_W+col.
- visited_count  out  clog2(GRID_W*GRID_H+1)  number of set visited bits.
- done  out  1  sticky; all cells visited.

Function
REQ-007 SHALL implement states IDLE, DECIDE, MOVE, WAIT_ACK, DONE.
REQ-008 IDLE SHALL go to DECIDE on the first cycle with enable=1.
REQ-009 DECIDE SHALL occur only when pos_x and pos_y low CELL_BITS bits are zero, and SHALL last exactly one cycle.
REQ-010 DECIDE SHALL set visited[cell] and SHALL increment visited_count only if the bit was previously 0.
REQ-011 DECIDE SHALL choose the direction: lowest-index btn bit that is set and whose direction is free; else keep current direction; then latch path_free for the chosen direction and go to MOVE.
REQ-012 A direction SHALL be free iff the corresponding wall bit is 0 and the step stays inside the grid; grid edges block regardless of wall bits.
REQ-013 On MOVE entry the speed counter SHALL load SPEED_FACTOR-1 and decrement each cycle with enable=1; at 0 the tick fires, i.e. SPEED_FACTOR enabled cycles after entry.
REQ-014 On tick with path_free=1: step the position by one pixel in direction, assert upd_valid, go to WAIT_ACK; with path_free=0: go to DECIDE, no position change.
REQ-015 In MOVE, while position is not cell-aligned, a set btn bit for the opposite direction SHALL reverse direction on the next cycle and set path_free=1; the speed counter is not reloaded.
REQ-016 WAIT_ACK SHALL hold upd_valid=1 and position stable until upd_ready=1; then deassert upd_valid next cycle and go to DECIDE if aligned, else MOVE.
REQ-017 When visited_count reaches GRID_W*GRID_H in DECIDE, the FSM SHALL enter DONE with done=1; DONE is left only by restart or rst.
REQ-018 restart SHALL return all state to reset values on the next edge and SHALL take priority over every other event, including upd_ready.
REQ-019 Position arithmetic SHALL never wrap; pos_x <= (GRID_W-1)*2^CELL_BITS and pos_y <= (GRID_H-1)*2^CELL_BITS at all times.

Reset
REQ-020 rst low SHALL asynchronously force: state IDLE, pos_x=0, pos_y=0, direction=2, path_free=0, counter=0, visited=0, visited_count=0, upd_valid=0, done=0.
REQ-021 Reset assertion mid-WAIT_ACK SHALL drop upd_valid immediately, without waiting for upd_ready.

Structure
REQ-022 Direction codes, state encoding and the cell-index functions SHALL be defined in a shared package maze_pkg.
REQ-023 Free-direction computation SHALL be a combinational sub-module maze_wall_lookup (cell col/row, walls -> four free flags).

Verification (defaults, upd_ready=1 unless stated)
REQ-024 Release rst, no walls, enable=1, btn=0 -> direction=2 blocked at (0,0); upd_valid never asserted; visited[0]=1; visited_count=1.
REQ-025 btn[0] held, no walls -> first upd_valid with pos_x=1 exactly 8 cycles after MOVE entry; after 32 steps pos_x=32, visited[1]=1, visited_count=2.
REQ-026 v_walls bit 1 set, btn[0] held at (0,0) -> no step; add btn[1] -> direction=1, pos_y=1 after 8 cycles.
REQ-027 Moving right at pos_x=10, pulse btn[2] -> direction=2 next cycle; next step gives pos_x=9.
REQ-028 upd_ready held low 20 cycles in WAIT_ACK -> upd_valid stays 1, position unchanged; rst pulsed low -> all outputs at reset values in the same cycle.
REQ-029 GRID_W=2, GRID_H=1, btn[0] held -> done=1 in DECIDE at (1,0); visited_count=2; restart -> done=0, pos_x=0.
